// File: rtl/ping_pong_pkg.sv
// ---------------------------------------------------------------------------
// ping_pong_pkg
//   Shared definitions for the ping-pong sequencer and the up/down counter it
//   drives. Both blocks size their count path from CNT_W so the bounds and
//   the feedback value always agree in width.
// ---------------------------------------------------------------------------
package ping_pong_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Sequencer states: wait for config, one-cycle counter reload,
  // counting bounces, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A run needs a non-empty range to bounce inside and at least one
  // direction change to wait for; anything else is rejected.
  function automatic logic cfg_is_legal(input cnt_t min_v,
                                        input cnt_t max_v,
                                        input cnt_t bounces);
    return (max_v > min_v) && (bounces != '0);
  endfunction

endpackage

// File: rtl/ping_pong_sequencer.sv
// ---------------------------------------------------------------------------
// ping_pong_sequencer
//   Controls an external ping-pong (up/down) counter. A configuration is
//   accepted in IDLE, the counter is reloaded for one cycle in LOAD, then the
//   block lets the counter run and counts direction changes ("bounces") until
//   the configured number is reached. Flip requests from outside are edge
//   detected, held until the counter sits strictly inside its range, and then
//   issued as a single ctr_flip pulse.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        config handshake (ready only in IDLE)
//   cfg_min, cfg_max, cfg_bounces range bounds and bounce target
//   flip_req                     level; each rising edge asks for one flip
//   pause                        freezes the counter while high
//   ctr_rst_n, ctr_enable,
//   ctr_flip                     control outputs to the counter
//   ctr_max, ctr_min             latched bounds for the counter
//   ctr_direction, ctr_out       counter feedback (direction 1 = counting up)
//   busy, done, err              run active / completion pulse / reject pulse
// ---------------------------------------------------------------------------
module ping_pong_sequencer
  import ping_pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,

  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_min,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic [CNT_W-1:0] cfg_bounces,

  input  logic             flip_req,
  input  logic             pause,

  output logic             ctr_rst_n,
  output logic             ctr_enable,
  output logic             ctr_flip,
  output logic [CNT_W-1:0] ctr_max,
  output logic [CNT_W-1:0] ctr_min,
  input  logic             ctr_direction,
  input  logic [CNT_W-1:0] ctr_out,

  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t state;
  cnt_t   target;
  cnt_t   bounce_cnt;
  logic   prev_dir;
  logic   flip_req_q;
  logic   flip_pending;

  logic   cfg_fire;
  logic   flip_edge;
  logic   ctr_interior;
  logic   bounce;
  cnt_t   bounce_next;

  assign cfg_fire  = cfg_valid & cfg_ready;
  assign flip_edge = flip_req & ~flip_req_q;

  // The counter is held in synchronous reset during LOAD, and also whenever
  // this block itself is in reset so both come out of reset together.
  assign ctr_rst_n  = rst_n & (state != LOAD);
  assign ctr_enable = (state == RUN) & ~pause;

  // Flipping at an endpoint would fight the counter's own turnaround, so a
  // flip is only issued strictly inside the range.
  assign ctr_interior = (ctr_out > ctr_min) && (ctr_out < ctr_max);
  assign ctr_flip     = flip_pending & ctr_enable & ctr_interior;

  // A bounce is any change of counter direction while it is actually
  // stepping, whether caused by an endpoint turnaround or by a flip.
  assign bounce      = ctr_enable & (ctr_direction != prev_dir);
  assign bounce_next = bounce_cnt + cnt_t'(1);

  // -------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // -------------------------------------------------------------------------
  // NOTE: every flop here uses non-blocking assignment so all of them update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ctr_max    <= '0;
      ctr_min    <= '0;
      target     <= '0;
      bounce_cnt <= '0;
      prev_dir   <= 1'b1;
    end else begin
      // done and err are single-cycle pulses unless re-asserted below.
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_fire) begin
            if (cfg_is_legal(cfg_min, cfg_max, cfg_bounces)) begin
              ctr_min   <= cfg_min;
              ctr_max   <= cfg_max;
              target    <= cfg_bounces;
              state     <= LOAD;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              // Rejected: bounds and target keep their previous values.
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          // The counter restarts at ctr_min counting up, so the reference
          // direction starts at "up" and no stale bounce is seen.
          bounce_cnt <= '0;
          prev_dir   <= 1'b1;
          state      <= RUN;
        end

        RUN: begin
          prev_dir <= ctr_direction;
          if (bounce) begin
            bounce_cnt <= bounce_next;
            // Leaving on the bounce that hits the target keeps bounce_cnt
            // from ever stepping past it, so it cannot wrap.
            if (bounce_next == target) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Flip request capture
  // -------------------------------------------------------------------------
  // Edges are remembered in a single pending bit, so several requests that
  // arrive before the flip can be issued collapse into one flip. Servicing
  // wins over a simultaneous new edge: that edge is taken as part of the
  // request just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_req_q   <= 1'b0;
      flip_pending <= 1'b0;
    end else begin
      flip_req_q <= flip_req;
      if ((state == IDLE) || (state == LOAD)) begin
        flip_pending <= 1'b0;
      end else if (ctr_flip) begin
        flip_pending <= 1'b0;
      end else if (flip_edge) begin
        flip_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_sequencer
//   Directed bench for ping_pong_sequencer. A small behavioural up/down
//   counter stands in for the counter that sits beside the sequencer in the
//   real system. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ping_pong_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_min;
  logic [3:0] cfg_max;
  logic [3:0] cfg_bounces;
  logic       flip_req;
  logic       pause;
  logic       ctr_rst_n;
  logic       ctr_enable;
  logic       ctr_flip;
  logic [3:0] ctr_max;
  logic [3:0] ctr_min;
  logic       ctr_direction;
  logic [3:0] ctr_out;
  logic       busy;
  logic       done;
  logic       err;

  int total;
  int bad;

  ping_pong_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_min       (cfg_min),
    .cfg_max       (cfg_max),
    .cfg_bounces   (cfg_bounces),
    .flip_req      (flip_req),
    .pause         (pause),
    .ctr_rst_n     (ctr_rst_n),
    .ctr_enable    (ctr_enable),
    .ctr_flip      (ctr_flip),
    .ctr_max       (ctr_max),
    .ctr_min       (ctr_min),
    .ctr_direction (ctr_direction),
    .ctr_out       (ctr_out),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ping-pong counter: sync reset to min counting up; at an
  // endpoint it turns around immediately; a flip reverses direction and
  // steps the other way in the same cycle.
  always @(posedge clk) begin
    if (!ctr_rst_n) begin
      ctr_out       <= ctr_min;
      ctr_direction <= 1'b1;
    end else if (ctr_enable) begin
      if (ctr_flip) begin
        ctr_direction <= ~ctr_direction;
        ctr_out       <= ctr_direction ? ctr_out - 4'd1 : ctr_out + 4'd1;
      end else if (ctr_direction) begin
        if (ctr_out >= ctr_max) begin
          ctr_direction <= 1'b0;
          ctr_out       <= ctr_out - 4'd1;
        end else begin
          ctr_out <= ctr_out + 4'd1;
        end
      end else begin
        if (ctr_out <= ctr_min) begin
          ctr_direction <= 1'b1;
          ctr_out       <= ctr_out + 4'd1;
        end else begin
          ctr_out <= ctr_out - 4'd1;
        end
      end
    end
  end

  // Present a config for one edge; returns on the falling edge after it.
  task automatic send_cfg(input logic [3:0] mn, input logic [3:0] mx,
                          input logic [3:0] bn);
    cfg_min     = mn;
    cfg_max     = mx;
    cfg_bounces = bn;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  // Step falling edges until the counter shows (value, direction).
  task automatic wait_out(input logic [3:0] v, input logic dir,
                          input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ctr_out === v && ctr_direction === dir) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_timeout: ctr_out=%0d never reached %0d", name, ctr_out, v);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b1;
    cfg_valid   = 1'b0;
    cfg_min     = 4'd0;
    cfg_max     = 4'd0;
    cfg_bounces = 4'd0;
    flip_req    = 1'b0;
    pause       = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b exp 1", cfg_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b exp 0", done); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err: got %b exp 0", err); end
    total++; if (ctr_enable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b exp 0", ctr_enable); end
    total++; if (ctr_flip !== 1'b0)  begin bad++; $display("FAIL reset_flip: got %b exp 0", ctr_flip); end
    total++; if (ctr_rst_n !== 1'b0) begin bad++; $display("FAIL reset_ctr_rst_n: got %b exp 0", ctr_rst_n); end
    total++; if (ctr_max !== 4'd0)   begin bad++; $display("FAIL reset_ctr_max: got %0d exp 0", ctr_max); end
    total++; if (ctr_min !== 4'd0)   begin bad++; $display("FAIL reset_ctr_min: got %0d exp 0", ctr_min); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ctr_rst_n !== 1'b1) begin bad++; $display("FAIL idle_ctr_rst_n: got %b exp 1", ctr_rst_n); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_cfg_ready: got %b exp 1", cfg_ready); end
  endtask

  task automatic test_basic_run;
    logic [3:0] exp_seq [8];
    exp_seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3};
    send_cfg(4'd2, 4'd5, 4'd2);
    // LOAD cycle
    total++; if (ctr_rst_n !== 1'b0) begin bad++; $display("FAIL load_ctr_rst_n: got %b exp 0", ctr_rst_n); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL load_busy: got %b exp 1", busy); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL load_cfg_ready: got %b exp 0", cfg_ready); end
    total++; if (ctr_enable !== 1'b0) begin bad++; $display("FAIL load_enable: got %b exp 0", ctr_enable); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL load_err: got %b exp 0", err); end
    total++; if (ctr_min !== 4'd2 || ctr_max !== 4'd5) begin
      bad++; $display("FAIL load_bounds: got %0d..%0d exp 2..5", ctr_min, ctr_max);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (ctr_out !== exp_seq[i]) begin bad++; $display("FAIL run_out[%0d]: got %0d exp %0d", i, ctr_out, exp_seq[i]); end
      total++; if (ctr_enable !== 1'b1 || ctr_rst_n !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL run_ctrl[%0d]: en=%b rst_n=%b done=%b exp 1 1 0", i, ctr_enable, ctr_rst_n, done);
      end
      // A config offered mid-run must be ignored, even an illegal one.
      if (i == 2) begin
        cfg_min = 4'd7; cfg_max = 4'd3; cfg_bounces = 4'd1; cfg_valid = 1'b1;
      end
      if (i == 3) begin
        cfg_valid = 1'b0;
        total++; if (err !== 1'b0 || ctr_min !== 4'd2) begin
          bad++; $display("FAIL run_cfg_ignored: err=%b min=%0d exp 0 2", err, ctr_min);
        end
      end
    end
    @(negedge clk);
    total++; if (done !== 1'b1)      begin bad++; $display("FAIL basic_done: got %b exp 1", done); end
    total++; if (ctr_out !== 4'd4)   begin bad++; $display("FAIL basic_done_out: got %0d exp 4", ctr_out); end
    total++; if (ctr_enable !== 1'b0) begin bad++; $display("FAIL basic_done_enable: got %b exp 0", ctr_enable); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle: done=%b busy=%b ready=%b exp 0 0 1", done, busy, cfg_ready);
    end
    total++; if (ctr_out !== 4'd4)   begin bad++; $display("FAIL basic_hold_out: got %0d exp 4", ctr_out); end
  endtask

  task automatic test_bad_cfg;
    logic [3:0] mins [3];
    logic [3:0] maxs [3];
    logic [3:0] bns  [3];
    mins = '{4'd7, 4'd4, 4'd2};
    maxs = '{4'd3, 4'd4, 4'd9};
    bns  = '{4'd2, 4'd2, 4'd0};
    for (int i = 0; i < 3; i++) begin
      send_cfg(mins[i], maxs[i], bns[i]);
      total++; if (err !== 1'b1)       begin bad++; $display("FAIL bad_cfg_err[%0d]: got %b exp 1", i, err); end
      total++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL bad_cfg_idle[%0d]: ready=%b busy=%b exp 1 0", i, cfg_ready, busy);
      end
      total++; if (ctr_rst_n !== 1'b1) begin bad++; $display("FAIL bad_cfg_rst_n[%0d]: got %b exp 1", i, ctr_rst_n); end
      total++; if (ctr_min !== 4'd2 || ctr_max !== 4'd5) begin
        bad++; $display("FAIL bad_cfg_bounds[%0d]: got %0d..%0d exp 2..5", i, ctr_min, ctr_max);
      end
      @(negedge clk);
      total++; if (err !== 1'b0 || ctr_rst_n !== 1'b1) begin
        bad++; $display("FAIL bad_cfg_pulse[%0d]: err=%b rst_n=%b exp 0 1", i, err, ctr_rst_n);
      end
    end
  endtask

  task automatic test_flip_interior;
    send_cfg(4'd0, 4'd15, 4'd1);
    wait_out(4'd5, 1'b1, "flip_int");
    flip_req = 1'b1;
    @(negedge clk);
    total++; if (ctr_flip !== 1'b1 || ctr_out !== 4'd6) begin
      bad++; $display("FAIL flip_int_pulse: flip=%b out=%0d exp 1 6", ctr_flip, ctr_out);
    end
    @(negedge clk);
    total++; if (ctr_flip !== 1'b0 || ctr_out !== 4'd5) begin
      bad++; $display("FAIL flip_int_after: flip=%b out=%0d exp 0 5", ctr_flip, ctr_out);
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flip_int_early_done: got %b exp 0", done); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL flip_int_done: got %b exp 1", done); end
    flip_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flip_endpoint;
    send_cfg(4'd2, 4'd5, 4'd3);
    wait_out(4'd4, 1'b1, "flip_end");
    flip_req = 1'b1;
    @(negedge clk);
    total++; if (ctr_out !== 4'd5 || ctr_flip !== 1'b0) begin
      bad++; $display("FAIL flip_end_held: out=%0d flip=%b exp 5 0", ctr_out, ctr_flip);
    end
    flip_req = 1'b0;
    @(negedge clk);
    total++; if (ctr_out !== 4'd4 || ctr_flip !== 1'b1) begin
      bad++; $display("FAIL flip_end_pulse: out=%0d flip=%b exp 4 1", ctr_out, ctr_flip);
    end
    @(negedge clk);
    total++; if (ctr_out !== 4'd5 || ctr_flip !== 1'b0) begin
      bad++; $display("FAIL flip_end_once: out=%0d flip=%b exp 5 0", ctr_out, ctr_flip);
    end
    @(negedge clk);
    total++; if (ctr_out !== 4'd4 || done !== 1'b0) begin
      bad++; $display("FAIL flip_end_last: out=%0d done=%b exp 4 0", ctr_out, done);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || ctr_out !== 4'd3) begin
      bad++; $display("FAIL flip_end_done: done=%b out=%0d exp 1 3", done, ctr_out);
    end
    @(negedge clk);
  endtask

  task automatic test_pause_merge;
    send_cfg(4'd2, 4'd5, 4'd2);
    wait_out(4'd3, 1'b1, "pause");
    pause    = 1'b1;
    flip_req = 1'b1;
    #1;
    total++; if (ctr_enable !== 1'b0) begin bad++; $display("FAIL pause_enable_now: got %b exp 0", ctr_enable); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ctr_out !== 4'd3 || ctr_enable !== 1'b0 || ctr_flip !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL pause_frozen[%0d]: out=%0d en=%b flip=%b busy=%b exp 3 0 0 1",
                        i, ctr_out, ctr_enable, ctr_flip, busy);
      end
      // Second rising edge while the first is still pending.
      flip_req = (i == 1);
    end
    pause    = 1'b0;
    flip_req = 1'b0;
    #1;
    total++; if (ctr_flip !== 1'b1 || ctr_enable !== 1'b1) begin
      bad++; $display("FAIL pause_release_flip: flip=%b en=%b exp 1 1", ctr_flip, ctr_enable);
    end
    @(negedge clk);
    total++; if (ctr_out !== 4'd2 || ctr_flip !== 1'b0) begin
      bad++; $display("FAIL pause_after_flip: out=%0d flip=%b exp 2 0", ctr_out, ctr_flip);
    end
    @(negedge clk);
    total++; if (ctr_out !== 4'd3 || ctr_flip !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL pause_merged: out=%0d flip=%b done=%b exp 3 0 0", ctr_out, ctr_flip, done);
    end
    @(negedge clk);
    total++; if (done !== 1'b1 || ctr_out !== 4'd4) begin
      bad++; $display("FAIL pause_done: done=%b out=%0d exp 1 4", done, ctr_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    send_cfg(4'd2, 4'd5, 4'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_status: busy=%b done=%b err=%b ready=%b exp 0 0 0 1", busy, done, err, cfg_ready);
    end
    total++; if (ctr_enable !== 1'b0 || ctr_flip !== 1'b0 || ctr_rst_n !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: en=%b flip=%b rst_n=%b exp 0 0 0", ctr_enable, ctr_flip, ctr_rst_n);
    end
    total++; if (ctr_max !== 4'd0 || ctr_min !== 4'd0) begin
      bad++; $display("FAIL midrst_bounds: got %0d..%0d exp 0..0", ctr_min, ctr_max);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || ctr_rst_n !== 1'b1) begin
        bad++; $display("FAIL midrst_after[%0d]: done=%b busy=%b ready=%b rst_n=%b exp 0 0 1 1",
                        i, done, busy, cfg_ready, ctr_rst_n);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_run();
    test_bad_cfg();
    test_flip_interior();
    test_flip_endpoint();
    test_pause_merge();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
